// File: rtl/comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, cascade
// encoding {lt,eq,gt} and the one-hot cascade constants.
package comparator_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cascade_t;

   localparam cascade_t CMP_LT = 3'b100;
   localparam cascade_t CMP_EQ = 3'b010;
   localparam cascade_t CMP_GT = 3'b001;

endpackage

// File: rtl/comparator_byte_stage.sv
// One 8-bit cascaded compare step: an undecided (EQ) cascade takes the
// unsigned a_byte vs b_byte result, a decided cascade passes through.
module comparator_byte_stage
   import comparator_pkg::*;
(
   input  logic [2:0] cas_in,
   input  logic [7:0] a_byte,
   input  logic [7:0] b_byte,
   output logic [2:0] cas_out
);

   cascade_t cas;

   always_comb begin
      cas     = cascade_t'(cas_in);
      cas_out = cas_in;
      if (cas.eq) begin
         if (a_byte < b_byte) begin
            cas_out = CMP_LT;
         end else if (a_byte > b_byte) begin
            cas_out = CMP_GT;
         end else begin
            cas_out = CMP_EQ;
         end
      end
   end

endmodule

// File: rtl/comparator_serial.sv
// Serial WORDS-byte magnitude comparator, MSB byte first, valid/ready input.
// Define COMPARATOR_SERIAL_EARLY_EXIT_EN to finish as soon as the result is decided.
module comparator_serial
   import comparator_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       lt_in,
   input  logic       eq_in,
   input  logic       gt_in,
   input  logic [7:0] a_byte,
   input  logic [7:0] b_byte,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       busy,
   output logic       done,
   output logic       lt_out,
   output logic       eq_out,
   output logic       gt_out
);

   localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   state_t         state, state_next;
   cascade_t       cas, cas_next;
   logic [CW-1:0]  cnt;
   logic [2:0]     stage_out;
   logic           accept;

   comparator_byte_stage u_stage (
      .cas_in  (cas),
      .a_byte  (a_byte),
      .b_byte  (b_byte),
      .cas_out (stage_out)
   );

   always_comb begin
      state_next = state;
      cas_next   = cas;
      byte_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               cas_next   = {lt_in, eq_in, gt_in};
               state_next = RUN;
            end
         end
         RUN: begin
            busy       = 1'b1;
            byte_ready = 1'b1;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
            // A decided cascade cannot change, so stop consuming bytes.
            if (!cas.eq) begin
               byte_ready = 1'b0;
               state_next = DONE;
            end
`endif
            accept = byte_ready & byte_valid;
            if (accept) begin
               cas_next = cascade_t'(stage_out);
               if (cnt == LAST) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cas    <= '0;
         cnt    <= '0;
         lt_out <= 1'b0;
         eq_out <= 1'b0;
         gt_out <= 1'b0;
      end else begin
         state <= state_next;
         cas   <= cas_next;
         if (state == IDLE && start) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
         end
         // Load on entry so the result is visible during the done cycle.
         if (state_next == DONE) begin
            {lt_out, eq_out, gt_out} <= cas_next;
         end
      end
   end

endmodule
